// File: rtl/droic_dataout_rx.sv
// Host-side receiver for the DROIC ClkOut/DataOut serial link: synchronizes both lines,
// deframes MSB-first words and buffers them in a 2-entry first-word-fall-through FIFO.
module droic_dataout_rx #(
  parameter int unsigned WORD_W      = 16,
  parameter int unsigned GAP_CYCLES  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              ClkOut,
  input  logic              DataOut,
  input  logic              En,
  output logic [WORD_W-1:0] WordData,
  output logic              WordValid,
  input  logic              WordReady,
  output logic              Overflow,
  output logic              FrameErr,
  output logic [15:0]       WordCount,
  input  logic              ClrErr
);

  localparam int unsigned BW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] data_sync;
  logic                   clk_d;
  logic                   rise;
  logic                   bit_in;

  state_t                 state, state_nxt;
  logic [BW-1:0]          bit_cnt, bit_cnt_nxt;
  logic [WORD_W-1:0]      shift_q, shift_nxt;
  logic [GW-1:0]          gap_cnt, gap_nxt;
  logic                   push_q, push_nxt;
  logic [WORD_W-1:0]      push_word, push_word_nxt;
  logic                   frame_set;

  logic [WORD_W-1:0]      mem [2];
  logic                   rd_ptr, wr_ptr;
  logic [1:0]             fifo_cnt;
  logic                   pop, accept, ovf_set;

  assign rise   = clk_sync[SYNC_STAGES-1] & ~clk_d;
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge Clk) begin
    if (Rst) begin
      clk_sync  <= '0;
      data_sync <= '0;
      clk_d     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ClkOut};
      data_sync <= {data_sync[SYNC_STAGES-2:0], DataOut};
      clk_d     <= clk_sync[SYNC_STAGES-1];
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_q   <= '0;
      gap_cnt   <= '0;
      push_q    <= 1'b0;
      push_word <= '0;
    end else begin
      state     <= state_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
      gap_cnt   <= gap_nxt;
      push_q    <= push_nxt;
      push_word <= push_word_nxt;
    end
  end

  // A sampled edge always wins over the gap timeout in the same cycle.
  always_comb begin
    state_nxt     = state;
    bit_cnt_nxt   = bit_cnt;
    shift_nxt     = shift_q;
    gap_nxt       = gap_cnt;
    push_nxt      = 1'b0;
    push_word_nxt = push_word;
    frame_set     = 1'b0;

    if (rise) begin
      gap_nxt = '0;
    end else if (gap_cnt != GW'(GAP_CYCLES)) begin
      gap_nxt = gap_cnt + GW'(1);
    end

    if (!En) begin
      state_nxt   = IDLE;
      bit_cnt_nxt = '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise) begin
            shift_nxt   = {shift_q[WORD_W-2:0], bit_in};
            bit_cnt_nxt = BW'(1);
            state_nxt   = SHIFT;
          end
        end
        SHIFT: begin
          if (rise) begin
            if (bit_cnt == BW'(WORD_W - 1)) begin
              push_nxt      = 1'b1;
              push_word_nxt = {shift_q[WORD_W-2:0], bit_in};
              shift_nxt     = {shift_q[WORD_W-2:0], bit_in};
              bit_cnt_nxt   = '0;
              state_nxt     = IDLE;
            end else begin
              shift_nxt   = {shift_q[WORD_W-2:0], bit_in};
              bit_cnt_nxt = bit_cnt + BW'(1);
            end
          end else if (gap_cnt == GW'(GAP_CYCLES)) begin
            frame_set   = 1'b1;
            shift_nxt   = '0;
            bit_cnt_nxt = '0;
            state_nxt   = IDLE;
          end
        end
        default: begin
          state_nxt   = IDLE;
          bit_cnt_nxt = '0;
        end
      endcase
    end
  end

  assign WordValid = (fifo_cnt != 2'd0);
  assign WordData  = mem[rd_ptr];
  assign pop       = WordValid & WordReady;
  // When full, a simultaneous pop frees the slot the incoming word lands in.
  assign accept    = push_q & ((fifo_cnt != 2'd2) | pop);
  assign ovf_set   = push_q & (fifo_cnt == 2'd2) & ~pop;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      rd_ptr    <= 1'b0;
      wr_ptr    <= 1'b0;
      fifo_cnt  <= 2'd0;
      WordCount <= '0;
      Overflow  <= 1'b0;
      FrameErr  <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= push_word;
        wr_ptr      <= ~wr_ptr;
        WordCount   <= WordCount + 16'd1;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, accept} - {1'b0, pop};
      Overflow <= ovf_set | (Overflow & ~ClrErr);
      FrameErr <= frame_set | (FrameErr & ~ClrErr);
    end
  end

endmodule
